// File: rtl/fetch_unit.sv
// Instruction fetch unit: fetches one word per instruction, holds it for execute,
// then advances pc (sequential, branch or jump) on commit. Halt opcode or fetch timeout stops it.
module fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        exec_done,
  input  logic        Jump,
  input  logic        Branch,
  input  logic        zero,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] retired,
  output logic        halted,
  output logic        fetch_err
);

  typedef enum logic [1:0] {StIdle, StFetch, StExec, StHalt} state_e;

  localparam logic [5:0] OpBeq  = 6'd5;
  localparam logic [5:0] OpBne  = 6'd6;
  localparam logic [5:0] OpHalt = 6'd63;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] retired_q, retired_d;
  logic [31:0] wait_q, wait_d;
  logic        fetch_err_q, fetch_err_d;

  logic [5:0]  opcode;
  logic        fetch_fire, timeout, commit, is_halt, take_branch;
  logic [31:0] branch_off, next_pc;

  assign opcode     = instr_q[31:26];
  assign is_halt    = (opcode == OpHalt);
  assign fetch_fire = (state_q == StFetch) && imem_ack;
  // wait_q counts prior ack-less FETCH cycles, so this fires on the (ACK_TIMEOUT+1)th one
  assign timeout    = (state_q == StFetch) && !imem_ack && (wait_q == ACK_TIMEOUT);
  assign commit     = (state_q == StExec) && exec_done;

  assign pc_plus4    = pc_q + 32'd4;
  assign branch_off  = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
  assign take_branch = Branch && (((opcode == OpBeq) && zero) || ((opcode == OpBne) && !zero));

  always_comb begin
    if (Jump) begin
      next_pc = {pc_plus4[31:28], instr_q[25:0], 2'b00};
    end else if (take_branch) begin
      next_pc = pc_plus4 + branch_off;
    end else begin
      next_pc = pc_plus4;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  state_d = StFetch;
      StFetch: begin
        if (fetch_fire) begin
          state_d = StExec;
        end else if (timeout) begin
          state_d = StHalt;
        end
      end
      StExec:  begin
        if (commit) begin
          state_d = is_halt ? StHalt : StFetch;
        end
      end
      StHalt:  state_d = StHalt;
      default: state_d = StIdle;
    endcase
  end

  // Output logic
  always_comb begin
    imem_req    = (state_q == StFetch);
    instr_valid = (state_q == StExec);
    halted      = (state_q == StHalt);
  end

  always_comb begin
    pc_d        = pc_q;
    instr_d     = instr_q;
    retired_d   = retired_q;
    fetch_err_d = fetch_err_q || timeout;
    wait_d      = 32'd0;
    if (state_q == StFetch && !imem_ack) begin
      wait_d = wait_q + 32'd1;
    end
    if (fetch_fire) begin
      instr_d = imem_rdata;
    end
    if (commit) begin
      retired_d = retired_q + 32'd1;
      if (!is_halt) begin
        pc_d = next_pc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q        <= RESET_PC;
      instr_q     <= 32'd0;
      retired_q   <= 32'd0;
      wait_q      <= 32'd0;
      fetch_err_q <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      retired_q   <= retired_d;
      wait_q      <= wait_d;
      fetch_err_q <= fetch_err_d;
    end
  end

  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign instr     = instr_q;
  assign retired   = retired_q;
  assign fetch_err = fetch_err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, sequential/branch/jump flow, halt, mid-fetch
// reset and ack timeout; a second instance starts at a high reset pc for the jump case.
module tb_fetch_unit;

  logic        clk;
  logic        rst_n, imem_ack, exec_done, Jump, Branch, zero;
  logic [31:0] imem_rdata;
  logic        imem_req, instr_valid, halted, fetch_err;
  logic [31:0] imem_addr, instr, pc, pc_plus4, retired;

  logic        rst_n_h, ack_h, done_h, jump_h, branch_h, zero_h;
  logic [31:0] rdata_h;
  logic        req_h, valid_h, halted_h, err_h;
  logic [31:0] addr_h, instr_h, pc_h, pc4_h, retired_h;

  int n_checks;
  int n_fails;
  logic [31:0] exp_retired;

  fetch_unit u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .instr      (instr),
    .instr_valid(instr_valid),
    .exec_done  (exec_done),
    .Jump       (Jump),
    .Branch     (Branch),
    .zero       (zero),
    .pc         (pc),
    .pc_plus4   (pc_plus4),
    .retired    (retired),
    .halted     (halted),
    .fetch_err  (fetch_err)
  );

  fetch_unit #(
    .RESET_PC   (32'h4000_0010),
    .ACK_TIMEOUT(15)
  ) u_dut_hi (
    .clk        (clk),
    .rst_n      (rst_n_h),
    .imem_req   (req_h),
    .imem_addr  (addr_h),
    .imem_ack   (ack_h),
    .imem_rdata (rdata_h),
    .instr      (instr_h),
    .instr_valid(valid_h),
    .exec_done  (done_h),
    .Jump       (jump_h),
    .Branch     (branch_h),
    .zero       (zero_h),
    .pc         (pc_h),
    .pc_plus4   (pc4_h),
    .retired    (retired_h),
    .halted     (halted_h),
    .fetch_err  (err_h)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One fetch (ack on the first FETCH cycle) followed by a commit with the given controls
  task automatic run_instr(input logic [31:0] word, input logic j, input logic b,
                           input logic z);
    imem_ack   = 1'b1;
    imem_rdata = word;
    tick();
    imem_ack   = 1'b0;
    imem_rdata = 32'd0;
    check("exec_valid", {31'd0, instr_valid}, 32'd1);
    check("exec_instr", instr, word);
    exec_done = 1'b1;
    Jump      = j;
    Branch    = b;
    zero      = z;
    tick();
    exec_done = 1'b0;
    Jump      = 1'b0;
    Branch    = 1'b0;
    zero      = 1'b0;
    exp_retired = exp_retired + 32'd1;
    check("retired", retired, exp_retired);
  endtask

  initial begin
    n_checks    = 0;
    n_fails     = 0;
    exp_retired = 32'd0;
    rst_n = 1'b0; imem_ack = 1'b0; exec_done = 1'b0;
    Jump = 1'b0; Branch = 1'b0; zero = 1'b0; imem_rdata = 32'd0;
    rst_n_h = 1'b0; ack_h = 1'b0; done_h = 1'b0;
    jump_h = 1'b0; branch_h = 1'b0; zero_h = 1'b0; rdata_h = 32'd0;

    // Reset and start-up
    tick();
    tick();
    check("rst_pc", pc, 32'd0);
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_retired", retired, 32'd0);
    check("rst_flags", {29'd0, halted, fetch_err, instr_valid}, 32'd0);
    rst_n = 1'b1;
    check("idle_req", {31'd0, imem_req}, 32'd0);
    tick();
    check("fetch_req", {31'd0, imem_req}, 32'd1);
    check("fetch_addr", imem_addr, 32'd0);
    check("pc_plus4", pc_plus4, 32'd4);

    // Sequential instruction, with a stray ack during EXEC that must be ignored
    imem_ack = 1'b1; imem_rdata = 32'h0000_1234;
    tick();
    check("exec_instr0", instr, 32'h0000_1234);
    check("exec_req0", {31'd0, imem_req}, 32'd0);
    imem_rdata = 32'hFFFF_FFFF;
    tick();
    imem_ack = 1'b0;
    check("exec_hold", instr, 32'h0000_1234);
    check("exec_valid0", {31'd0, instr_valid}, 32'd1);
    exec_done = 1'b1;
    tick();
    exec_done = 1'b0;
    exp_retired = 32'd1;
    check("seq_addr", imem_addr, 32'h4);
    check("seq_retired", retired, exp_retired);
    check("seq_req", {31'd0, imem_req}, 32'd1);

    // Jump to 0x10, then branch cases from there
    run_instr(32'h0800_0004, 1'b1, 1'b0, 1'b0);
    check("jmp_pc10", pc, 32'h10);
    run_instr(32'h1400_FFFE, 1'b0, 1'b1, 1'b1);
    check("beq_taken", pc, 32'h0C);
    run_instr(32'h0800_0004, 1'b1, 1'b0, 1'b0);
    run_instr(32'h1800_FFFE, 1'b0, 1'b1, 1'b1);
    check("bne_not_taken", pc, 32'h14);
    run_instr(32'h0800_0004, 1'b1, 1'b0, 1'b0);
    run_instr(32'h1800_FFFE, 1'b0, 1'b1, 1'b0);
    check("bne_taken", pc, 32'h0C);
    run_instr(32'h1400_0003, 1'b0, 1'b0, 1'b1);
    check("beq_no_branch_sig", pc, 32'h10);
    run_instr(32'h1400_0003, 1'b0, 1'b1, 1'b1);
    check("beq_fwd", pc, 32'h20);

    // Halt: pc frozen, retired still counts, no more requests
    run_instr(32'hFC00_0000, 1'b1, 1'b0, 1'b0);
    check("halt_flag", {31'd0, halted}, 32'd1);
    check("halt_pc", pc, 32'h20);
    check("halt_req", {31'd0, imem_req}, 32'd0);
    imem_ack = 1'b1; exec_done = 1'b1; Jump = 1'b1;
    repeat (3) tick();
    imem_ack = 1'b0; exec_done = 1'b0; Jump = 1'b0;
    check("halt_stay", {30'd0, halted, imem_req}, 32'd2);
    check("halt_pc_stay", pc, 32'h20);
    check("halt_retired", retired, exp_retired);

    // Reset during FETCH at pc=0x20 overrides a simultaneous ack
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    exp_retired = 32'd0;
    tick();
    run_instr(32'h0800_0008, 1'b1, 1'b0, 1'b0);
    check("mid_addr", imem_addr, 32'h20);
    check("mid_req", {31'd0, imem_req}, 32'd1);
    rst_n = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    rst_n = 1'b1; imem_ack = 1'b0; imem_rdata = 32'd0;
    check("mid_rst_pc", pc, 32'd0);
    check("mid_rst_instr", instr, 32'd0);
    check("mid_rst_retired", retired, 32'd0);
    check("mid_rst_idle", {30'd0, imem_req, instr_valid}, 32'd0);
    tick();
    check("mid_restart", {31'd0, imem_req}, 32'd1);
    check("mid_restart_addr", imem_addr, 32'd0);

    // Timeout: 16 ack-less FETCH cycles
    repeat (15) tick();
    check("to_not_yet", {30'd0, fetch_err, imem_req}, 32'd1);
    tick();
    check("to_err", {31'd0, fetch_err}, 32'd1);
    check("to_halted", {31'd0, halted}, 32'd1);
    check("to_req", {31'd0, imem_req}, 32'd0);
    imem_ack = 1'b1; imem_rdata = 32'h1234_5678; exec_done = 1'b1;
    repeat (3) tick();
    imem_ack = 1'b0; exec_done = 1'b0;
    check("to_ack_ignored", instr, 32'd0);
    check("to_sticky", {29'd0, fetch_err, halted, instr_valid}, 32'd6);

    // Jump priority over Branch at a high pc
    tick();
    rst_n_h = 1'b1;
    tick();
    check("hi_addr", addr_h, 32'h4000_0010);
    ack_h = 1'b1; rdata_h = 32'h3000_0100;
    tick();
    ack_h = 1'b0;
    done_h = 1'b1; jump_h = 1'b1; branch_h = 1'b1; zero_h = 1'b1;
    tick();
    done_h = 1'b0; jump_h = 1'b0; branch_h = 1'b0; zero_h = 1'b0;
    check("hi_jump_pc", pc_h, 32'h4000_0400);
    check("hi_retired", retired_h, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
